inst_fetcher: RTL and testbench

Instruction fetch stage between the program counter and the IF/ID register. It latches the current PC and reads the 32-bit instruction as four little-endian byte reads over the byte-wide memory port. It then presents the instruction with its PC to IF/ID. While a fetch is in progress it holds the PC through the staller.

---
 rtl/inst_fetcher.sv | 118 +++++++++++
 tb/tb_inst_fetcher.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: reads a 32-bit instruction as four little-endian byte reads
// and presents it with its PC to IF/ID, holding the PC through the staller meanwhile.
module inst_fetcher #(
    parameter int unsigned addrWidth = 32,
    parameter int unsigned instWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [addrWidth-1:0] PC,
    input  logic                 fetch_stall,
    input  logic                 flush,
    output logic                 mem_req,
    output logic [addrWidth-1:0] mem_addr,
    input  logic [7:0]           mem_rdata,
    input  logic                 mem_ack,
    output logic [instWidth-1:0] inst,
    output logic [addrWidth-1:0] inst_pc,
    output logic                 inst_valid,
    output logic                 if_busy
);

    typedef enum logic [1:0] {StIdle, StFetch, StValid} state_e;

    state_e                 state_q, state_d;
    logic [addrWidth-1:0]   addr_q, addr_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [23:0]            byte_buf_q, byte_buf_d;
    logic [instWidth-1:0]   inst_q, inst_d;
    logic [addrWidth-1:0]   inst_pc_q, inst_pc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            cnt_q      <= 2'd0;
            byte_buf_q <= 24'd0;
            inst_q     <= '0;
            inst_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            byte_buf_q <= byte_buf_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: if (mem_ack && (cnt_q == 2'd3)) state_d = StValid;
            StValid: if (!fetch_stall) state_d = StFetch;
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    always_comb begin
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        byte_buf_d = byte_buf_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    addr_d = PC;
                    cnt_d  = 2'd0;
                end
                StFetch: begin
                    if (mem_ack) begin
                        cnt_d = cnt_q + 2'd1;
                        case (cnt_q)
                            2'd0: byte_buf_d[7:0]   = mem_rdata;
                            2'd1: byte_buf_d[15:8]  = mem_rdata;
                            2'd2: byte_buf_d[23:16] = mem_rdata;
                            default: begin
                                inst_d    = {mem_rdata, byte_buf_q};
                                inst_pc_d = addr_q;
                            end
                        endcase
                    end
                end
                StValid: begin
                    if (!fetch_stall) begin
                        addr_d = PC;
                        cnt_d  = 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_addr = '0;
        if_busy  = 1'b1;
        case (state_q)
            StFetch: begin
                mem_req  = 1'b1;
                mem_addr = addr_q + addrWidth'(cnt_q);
            end
            StValid: if_busy = fetch_stall;
            default: ;
        endcase
    end

    assign inst_valid = (state_q == StValid);
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: byte-wide memory responder, PC model and a scoreboard
// of expected (pc, inst) pairs checked as IF/ID consumes each instruction.
module tb_inst_fetcher;

    logic        clk;
    logic        rst;
    logic [31:0] PC;
    logic        fetch_stall;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        if_busy;

    inst_fetcher #(
        .addrWidth(32),
        .instWidth(32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PC         (PC),
        .fetch_stall(fetch_stall),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .if_busy    (if_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    int          checks;
    int          errors;
    int          consumed;
    int          k;
    int          wait_left;
    int          wait_max;
    logic [31:0] base;
    logic [31:0] redirect_pc;
    bit          redirect_en;
    bit          stray;

    function automatic logic [7:0] mb(input logic [31:0] a);
        logic [7:0] t[4];
        t = '{8'h13, 8'h05, 8'h10, 8'h00};
        if (a < 32'd4) return t[a[1:0]];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] model(input logic [31:0] pc);
        return {mb(pc + 32'd3), mb(pc + 32'd2), mb(pc + 32'd1), mb(pc)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = model(pc);
        exp_q.push_back(e);
    endtask

    // One clock: sample at negedge, consume/respond/redirect, then return #1 after posedge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        check("if_busy", {31'd0, if_busy}, {31'd0, !(inst_valid && !fetch_stall)});
        if (inst_valid && !fetch_stall && !flush) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("inst", inst, e.inst);
                check("inst_pc", inst_pc, e.pc);
            end
            consumed++;
            PC   = PC + 32'd4;
            base = PC;
            k    = 0;
            push_exp(PC);
        end
        if (mem_req) begin
            check("mem_addr", mem_addr, base + 32'(k));
            if (wait_left == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mb(mem_addr);
                k++;
                wait_left = int'($urandom_range(wait_max, 0));
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 8'($urandom);
                wait_left--;
            end
        end else begin
            mem_ack   = stray;
            mem_rdata = 8'hFF;
        end
        if (redirect_en) begin
            PC   = redirect_pc;
            base = PC;
            k    = 0;
            exp_q.delete();
            push_exp(PC);
            redirect_en = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int target, input int budget);
        for (int i = 0; i < budget && consumed < target; i++) step();
        check("progress", 32'(consumed), 32'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_busy"}, {31'd0, if_busy}, 32'd1);
        check({tag, "_inst"}, inst, 32'd0);
        check({tag, "_pc"}, inst_pc, 32'd0);
    endtask

    initial begin
        checks = 0; errors = 0; consumed = 0; k = 0;
        wait_left = 0; wait_max = 0; base = 32'd0;
        redirect_en = 1'b0; redirect_pc = 32'd0; stray = 1'b0;
        rst = 1'b1; PC = 32'd0; fetch_stall = 1'b0; flush = 1'b0;
        mem_ack = 1'b0; mem_rdata = 8'd0;
        push_exp(32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // First fetch: valid exactly 5 posedges after reset release.
        for (int i = 1; i <= 5; i++) begin
            step();
            check("latency", {31'd0, inst_valid}, (i == 5) ? 32'd1 : 32'd0);
        end
        check("first_inst", inst, 32'h00100513);
        check("first_pc", inst_pc, 32'd0);
        step();
        check("valid_one_cycle", {31'd0, inst_valid}, 32'd0);
        check("refetch_req", {31'd0, mem_req}, 32'd1);

        // Back-to-back fetches from 4 onward.
        run_until(3, 40);

        // Stall while presenting.
        for (int i = 0; i < 20 && !inst_valid; i++) step();
        check("wait_valid", {31'd0, inst_valid}, 32'd1);
        fetch_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", {31'd0, inst_valid}, 32'd1);
            check("stall_inst", inst, exp_q[0].inst);
            check("stall_req", {31'd0, mem_req}, 32'd0);
            check("stall_busy", {31'd0, if_busy}, 32'd1);
        end
        fetch_stall = 1'b0;
        run_until(consumed + 1, 10);

        // Variable ack latency.
        wait_max = 3;
        run_until(consumed + 4, 200);
        wait_max = 0;

        // Flush while acking the third byte.
        for (int i = 0; i < 40 && !(mem_req && k == 2 && wait_left == 0); i++) step();
        check("flush_setup", 32'(k), 32'd2);
        flush = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        flush = 1'b0;
        check("flush_valid", {31'd0, inst_valid}, 32'd0);
        check("flush_req", {31'd0, mem_req}, 32'd0);
        check("flush_busy", {31'd0, if_busy}, 32'd1);
        run_until(consumed + 1, 20);

        // Asynchronous reset mid-fetch, then stray acks.
        for (int i = 0; i < 40 && !(mem_req && k == 1); i++) step();
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        stray = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        rst = 1'b0;
        step();
        stray = 1'b0;
        run_until(consumed + 1, 20);

        // Address wrap-around.
        flush = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        flush = 1'b0;
        run_until(consumed + 1, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
